// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan driver: one digit per slot, dead time at slot start,
// double-buffered display data that only changes at frame boundaries.
module led_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 8,
  parameter int BLANK    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  lzb,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     gate,
  output logic                  frame_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PRESCALE - BLANK - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_wrap;

  logic [4*DIGITS-1:0] r_sh_value;
  logic [DIGITS-1:0]   r_sh_dp;
  logic                r_sh_lzb;
  logic                r_pending;
  logic [4*DIGITS-1:0] r_dsp_value;
  logic [DIGITS-1:0]   r_dsp_dp;
  logic                r_dsp_lzb;
  logic                r_framed;

  logic [7:0]          r_seg;
  logic [DIGITS-1:0]   r_gate;
  logic                r_frame_done;
  logic [7:0]          w_seg_next;
  logic [DIGITS-1:0]   w_gate_next;
  logic                w_frame_done_next;

  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_lz;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BLANK;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt + 1'b1;
    w_idx_next   = r_idx;
    w_wrap       = 1'b0;
    case (r_state)
      ST_BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_next = ST_DRIVE;
          w_cnt_next   = '0;
        end
      end
      ST_DRIVE: begin
        if (r_cnt == DRIVE_LAST) begin
          w_state_next = ST_BLANK;
          w_cnt_next   = '0;
          if (r_idx == IDX_LAST) begin
            w_idx_next = '0;
            w_wrap     = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
    endcase
  end

  // A load coinciding with the wrap still commits the older shadow; the new data waits a frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_value  <= '0;
      r_sh_dp     <= '0;
      r_sh_lzb    <= 1'b0;
      r_pending   <= 1'b0;
      r_dsp_value <= '0;
      r_dsp_dp    <= '0;
      r_dsp_lzb   <= 1'b0;
      r_framed    <= 1'b0;
    end else begin
      if (w_wrap && r_pending) begin
        r_dsp_value <= r_sh_value;
        r_dsp_dp    <= r_sh_dp;
        r_dsp_lzb   <= r_sh_lzb;
      end
      if (load) begin
        r_sh_value <= value;
        r_sh_dp    <= dp;
        r_sh_lzb   <= lzb;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
      if (w_wrap) begin
        r_framed <= 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi] = r_dsp_value[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign w_lz[gi] = 1'b0;
      end else begin : g_upper
        assign w_lz[gi] = r_dsp_lzb & ~|r_dsp_value[4*DIGITS-1:4*gi];
      end
    end
  endgenerate

  // Outputs are registered from the current state, so they trail the FSM by one cycle.
  always_comb begin
    w_seg_next        = '0;
    w_gate_next       = '0;
    w_frame_done_next = r_framed && (r_state == ST_BLANK) && (r_cnt == '0) && (r_idx == '0);
    if (r_state == ST_DRIVE) begin
      w_gate_next = DIGITS'(1) << r_idx;
      w_seg_next  = {r_dsp_dp[r_idx], w_lz[r_idx] ? 7'd0 : seg_decode(w_nib[r_idx])};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seg        <= '0;
      r_gate       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_next;
      r_gate       <= w_gate_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  assign seg        = r_seg;
  assign gate       = r_gate;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_led_scan_driver.sv
// Directed bench for led_scan_driver (DIGITS=4, PRESCALE=8, BLANK=2): frame-by-frame
// checks of blanking, gating, decoding, load timing and reset behaviour.
module tb_led_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lzb;
  logic [7:0]  seg;
  logic [3:0]  gate;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0]  pos;
    logic [15:0] v;
    logic [3:0]  d;
    logic        z;
  } ld_t;

  always #5 clk = ~clk;

  led_scan_driver #(.DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .value      (value),
    .dp         (dp),
    .lzb        (lzb),
    .seg        (seg),
    .gate       (gate),
    .frame_done (frame_done)
  );

  function automatic ld_t mk(input int pos, input logic [15:0] v, input logic [3:0] d, input logic z);
    ld_t l;
    l.pos = 8'(pos);
    l.v   = v;
    l.d   = d;
    l.z   = z;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply(input ld_t l);
    value = l.v;
    dp    = l.d;
    lzb   = l.z;
    load  = 1'b1;
  endtask

  // Runs one 32-cycle frame from a frame boundary; exp packs {d3,d2,d1,d0} segment bytes.
  task automatic run_frame(input string name, input logic [31:0] exp, input logic fd_exp,
                           input ld_t la, input ld_t lb);
    for (int t = 1; t <= 32; t++) begin
      int         p;
      int         d;
      logic [3:0] oh;
      if (int'(la.pos) == t) apply(la);
      else if (int'(lb.pos) == t) apply(lb);
      tick();
      load = 1'b0;
      p  = (t - 1) % 8;
      d  = (t - 1) / 8;
      oh = 4'b0001 << d;
      if (p == 0) begin
        chk($sformatf("%s d%0d blank gate", name, d), 32'(gate), 32'h0);
        chk($sformatf("%s d%0d blank seg", name, d), 32'(seg), 32'h0);
        chk($sformatf("%s d%0d frame_done", name, d), 32'(frame_done), (d == 0) ? 32'(fd_exp) : 32'h0);
        $display("%s digit %0d slot start: gate=%b seg=%h frame_done=%b", name, d, gate, seg, frame_done);
      end else if (p == 1) begin
        chk($sformatf("%s d%0d blank2 gate", name, d), 32'(gate), 32'h0);
        if (d == 0) chk($sformatf("%s frame_done width", name), 32'(frame_done), 32'h0);
      end else if (p == 2 || p == 7) begin
        chk($sformatf("%s d%0d p%0d gate", name, d, p), 32'(gate), 32'(oh));
        chk($sformatf("%s d%0d p%0d seg", name, d, p), 32'(seg), 32'(exp[d*8 +: 8]));
      end
    end
  endtask

  initial begin
    ld_t none;
    none  = mk(0, 16'h0, 4'h0, 1'b0);
    rst   = 1'b0;
    load  = 1'b1;
    value = 16'h1234;
    dp    = 4'hF;
    lzb   = 1'b1;
    repeat (3) tick();
    chk("reset seg", 32'(seg), 32'h0);
    chk("reset gate", 32'(gate), 32'h0);
    chk("reset frame_done", 32'(frame_done), 32'h0);
    $display("reset held: seg=%h gate=%b frame_done=%b", seg, gate, frame_done);
    load = 1'b0;
    rst  = 1'b1;

    run_frame("F0", 32'h3F3F3F3F, 1'b0, none, none);
    run_frame("F1", 32'h3F3F3F3F, 1'b1, mk(12, 16'h12AF, 4'h0, 1'b0), none);
    run_frame("F2", 32'h065B7771, 1'b1, mk(5, 16'h0050, 4'h0, 1'b1), none);
    run_frame("F3", 32'h00006D3F, 1'b1, mk(20, 16'h0000, 4'h0, 1'b1), none);
    run_frame("F4", 32'h0000003F, 1'b1, mk(3, 16'h0000, 4'b1000, 1'b1), none);
    run_frame("F5", 32'h8000003F, 1'b1, mk(4, 16'h1111, 4'h0, 1'b0), mk(25, 16'h8888, 4'h0, 1'b0));
    run_frame("F6", 32'h7F7F7F7F, 1'b1, mk(10, 16'h3333, 4'h0, 1'b0), mk(32, 16'h4567, 4'b0101, 1'b0));
    run_frame("F7", 32'h4F4F4F4F, 1'b1, none, none);
    run_frame("F8", 32'h66ED7D87, 1'b1, none, none);

    // Pending load, then reset in the middle of digit 1's drive window.
    apply(mk(1, 16'hBCDE, 4'h0, 1'b0));
    tick();
    load = 1'b0;
    repeat (11) tick();
    chk("pre-reset gate", 32'(gate), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("async reset gate", 32'(gate), 32'h0);
    chk("async reset seg", 32'(seg), 32'h0);
    chk("async reset frame_done", 32'(frame_done), 32'h0);
    $display("mid-drive reset: gate=%b seg=%h frame_done=%b", gate, seg, frame_done);
    repeat (2) tick();
    rst = 1'b1;

    run_frame("R0", 32'h3F3F3F3F, 1'b0, none, none);
    run_frame("R1", 32'h3F3F3F3F, 1'b1, none, none);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
